// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared types and constants for the PPU OAM write-port controller.
//   dma_state_t  : sequencing states of the $4014 page DMA
//   REG_OAMADDR  : reg_sel value selecting $2003 (OAM pointer load)
//   REG_OAMDATA  : reg_sel value selecting $2004 (OAM data write)
//   OAM_SIZE     : number of bytes in primary OAM
// ---------------------------------------------------------------------------
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        GET   = 3'd3,
        PUT   = 3'd4
    } dma_state_t;

    localparam logic REG_OAMADDR = 1'b0;
    localparam logic REG_OAMDATA = 1'b1;
    localparam int   OAM_SIZE    = 256;

endpackage

// File: rtl/ppu_oam_dma.sv
// ---------------------------------------------------------------------------
// ppu_oam_dma
// Controller and arbiter for the PPU's primary OAM write port. Runs the
// $4014 page DMA (halt CPU, read page $XX00-$XXFF, write into OAM starting at
// the OAM pointer), owns the $2003 pointer and serialises $2004 writes onto
// the same port.
//
// Ports:
//   clk          in   PPU clock
//   reset        in   asynchronous, active-high reset
//   cpu_ce       in   CPU-cycle enable; all sequencing advances only when high
//   dma_start    in   CPU write to $4014
//   dma_page     in   [7:0] source page for the DMA
//   reg_wr       in   CPU write to $2003/$2004
//   reg_sel      in   0 = $2003 OAMADDR, 1 = $2004 OAMDATA
//   reg_data     in   [7:0] CPU write data
//   rendering    in   PPU is rendering
//   mem_addr     out  [ADDR_W-1:0] DMA read address
//   mem_rd       out  DMA read strobe (gated with cpu_ce)
//   mem_data_in  in   [7:0] CPU bus read data, valid at end of a GET cycle
//   cpu_rdy      out  0 halts the CPU
//   oam_addr     out  [7:0] OAM write address / current pointer
//   oam_data     out  [7:0] OAM write data
//   oam_we       out  OAM write enable (gated with cpu_ce)
//   busy         out  DMA in progress
//   done         out  one-cpu_ce pulse after the final PUT
// ---------------------------------------------------------------------------
module ppu_oam_dma
    import ppu_pkg::*;
#(
    parameter int XFER_LEN = 256,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              dma_start,
    input  logic [7:0]        dma_page,
    input  logic              reg_wr,
    input  logic              reg_sel,
    input  logic [7:0]        reg_data,
    input  logic              rendering,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data_in,
    output logic              cpu_rdy,
    output logic [7:0]        oam_addr,
    output logic [7:0]        oam_data,
    output logic              oam_we,
    output logic              busy,
    output logic              done
);

    dma_state_t state;
    dma_state_t state_next;
    logic       parity;
    logic [7:0] page;
    logic [7:0] cnt;
    logic [7:0] oam_ptr;
    logic [7:0] data_latch;

    logic last_put;
    logic reg_accept;
    logic data_wr;

    assign last_put   = (cnt == 8'(XFER_LEN - 1));
    // Register writes are only honoured while no DMA owns the port.
    assign reg_accept = (state == IDLE) && reg_wr;
    assign data_wr    = reg_accept && (reg_sel == REG_OAMDATA) && !rendering;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dma_start) state_next = HALT;
            // GET must fall on parity=0; an even-parity HALT needs one more
            // dummy cycle to reach it.
            HALT:    state_next = parity ? GET : ALIGN;
            ALIGN:   state_next = GET;
            GET:     state_next = PUT;
            PUT:     state_next = last_put ? IDLE : GET;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            parity     <= 1'b0;
            page       <= 8'h00;
            cnt        <= 8'h00;
            oam_ptr    <= 8'h00;
            data_latch <= 8'h00;
            done       <= 1'b0;
        end else if (cpu_ce) begin
            parity <= ~parity;
            state  <= state_next;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Register effect lands first, so a same-cycle DMA
                    // starts from the updated pointer.
                    if (reg_wr) begin
                        if (reg_sel == REG_OAMADDR)
                            oam_ptr <= reg_data;
                        else if (rendering)
                            oam_ptr <= oam_ptr + 8'd4;
                        else
                            oam_ptr <= oam_ptr + 8'd1;
                    end
                    if (dma_start) begin
                        page <= dma_page;
                        cnt  <= 8'h00;
                    end
                end
                GET: data_latch <= mem_data_in;
                PUT: begin
                    oam_ptr <= oam_ptr + 8'd1;
                    cnt     <= cnt + 8'd1;
                    if (last_put)
                        done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Moore decode; strobes are gated with cpu_ce so the sprite unit and the
    // CPU bus can use them unqualified. reset also masks the $2004 path,
    // which otherwise would follow reg_wr straight through.
    assign cpu_rdy  = (state == IDLE);
    assign busy     = (state != IDLE);
    assign mem_rd   = cpu_ce && (state == GET);
    assign mem_addr = (state == GET) ? ADDR_W'({page, cnt}) : '0;
    assign oam_we   = cpu_ce && !reset && ((state == PUT) || data_wr);
    assign oam_addr = oam_ptr;
    assign oam_data = (state == PUT) ? data_latch : reg_data;

endmodule

// File: tb/tb_ppu_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_ppu_oam_dma
// Self-checking bench for ppu_oam_dma: a table of register-write vectors,
// randomised idle register traffic against a reference OAM/pointer model,
// and DMA sequences (odd/even start parity, pointer wrap, reset abort).
// ---------------------------------------------------------------------------
module tb_ppu_oam_dma;
    import ppu_pkg::*;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_ce;
    logic              dma_start;
    logic [7:0]        dma_page;
    logic              reg_wr;
    logic              reg_sel;
    logic [7:0]        reg_data;
    logic              rendering;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data_in;
    logic              cpu_rdy;
    logic [7:0]        oam_addr;
    logic [7:0]        oam_data;
    logic              oam_we;
    logic              busy;
    logic              done;

    ppu_oam_dma #(.XFER_LEN(256), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_ce     (cpu_ce),
        .dma_start  (dma_start),
        .dma_page   (dma_page),
        .reg_wr     (reg_wr),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .rendering  (rendering),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data_in(mem_data_in),
        .cpu_rdy    (cpu_rdy),
        .oam_addr   (oam_addr),
        .oam_data   (oam_data),
        .oam_we     (oam_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // CPU memory image: page $02 holds i^$5A, other pages are distinct.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'h02);
    endfunction

    assign mem_data_in = mem_rd ? src_byte(mem_addr) : 8'hEE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observation state, all owned by the single stimulus process.
    int          ce_count;
    int          halt_cycles;
    int          done_pulses;
    int          parity_viol;
    logic [15:0] rd_q[$];
    logic [7:0]  put_q[$];
    logic [7:0]  sink[256];
    logic [7:0]  exp_oam[256];
    logic [7:0]  model_ptr;

    task automatic sample();
        if (!reset && cpu_ce) begin
            if (!cpu_rdy) halt_cycles++;
            if (done) done_pulses++;
            if (mem_rd && (ce_count % 2) != 0) parity_viol++;
            if (oam_we && !cpu_rdy && (ce_count % 2) != 1) parity_viol++;
            if (mem_rd) rd_q.push_back(mem_addr);
            if (oam_we && !cpu_rdy) put_q.push_back(oam_addr);
            ce_count++;
        end
        if (oam_we) sink[oam_addr] = oam_data;
    endtask

    // Inputs change at posedge+1; outputs are looked at 3 ns later.
    task automatic settle();
        #3;
        sample();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reg(input logic ce, input logic wr, input logic sel,
                             input logic [7:0] data, input logic rend);
        if (ce && wr) begin
            if (sel == REG_OAMADDR) begin
                model_ptr = data;
            end else if (!rend) begin
                exp_oam[model_ptr] = data;
                model_ptr = model_ptr + 8'd1;
            end else begin
                model_ptr = model_ptr + 8'd4;
            end
        end
    endtask

    task automatic idle_op(input logic ce, input logic wr, input logic sel,
                           input logic [7:0] data, input logic rend);
        cpu_ce = ce; reg_wr = wr; reg_sel = sel; reg_data = data; rendering = rend;
        dma_start = 1'b0;
        settle();
        advance();
        model_reg(ce, wr, sel, data, rend);
        reg_wr = 1'b0;
    endtask

    function automatic int oam_diff();
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (sink[i] !== exp_oam[i]) bad++;
        return bad;
    endfunction

    // Make the HALT cycle (the one after the start cycle) land on want_par.
    task automatic align_parity(input int want_par);
        if ((1 - (ce_count % 2)) != want_par)
            idle_op(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_dma(input string tag, input logic [7:0] page,
                           input logic with_addr, input logic [7:0] addr_val,
                           input int ce_pct, input logic noise, input int abort_at);
        int          exp_len;
        int          guard;
        int          bad;
        logic [7:0]  ptr0;
        halt_cycles = 0; done_pulses = 0; parity_viol = 0;
        rd_q.delete(); put_q.delete();
        exp_len = ((1 - (ce_count % 2)) == 1) ? 513 : 514;

        cpu_ce = 1'b1; dma_start = 1'b1; dma_page = page;
        reg_wr = with_addr; reg_sel = REG_OAMADDR; reg_data = addr_val;
        rendering = 1'($urandom_range(0, 1));
        settle();
        check({tag, "_start_rdy"}, {31'd0, cpu_rdy}, 32'd1);
        advance();
        model_reg(1'b1, with_addr, REG_OAMADDR, addr_val, 1'b0);
        ptr0 = model_ptr;
        dma_start = 1'b0; reg_wr = 1'b0;
        check({tag, "_halt_entry"}, {30'd0, busy, cpu_rdy}, 32'd2);

        guard = 0;
        while (guard < 6000) begin
            cpu_ce = ($urandom_range(0, 99) < ce_pct);
            if (noise && !cpu_rdy) begin
                reg_wr    = 1'($urandom_range(0, 1));
                reg_sel   = 1'($urandom_range(0, 1));
                reg_data  = 8'($urandom_range(0, 255));
                dma_start = ($urandom_range(0, 7) == 0);
                dma_page  = 8'($urandom_range(0, 255));
                rendering = 1'($urandom_range(0, 1));
            end else begin
                reg_wr = 1'b0; dma_start = 1'b0;
            end
            settle();
            advance();
            guard++;
            if (abort_at > 0 && put_q.size() >= abort_at) break;
            if (cpu_rdy && done_pulses > 0) break;
        end
        reg_wr = 1'b0; dma_start = 1'b0;
        check({tag, "_timeout"}, {31'd0, guard < 6000}, 32'd1);

        if (abort_at > 0) begin
            reset = 1'b1;
            #1;
            check({tag, "_abort_rdy"}, {31'd0, cpu_rdy}, 32'd1);
            check({tag, "_abort_busy"}, {31'd0, busy}, 32'd0);
            check({tag, "_abort_we"}, {31'd0, oam_we}, 32'd0);
            cpu_ce = 1'b1;
            for (int k = 0; k < 3; k++) begin
                settle();
                advance();
            end
            reset = 1'b0;
            ce_count = 0;
            model_ptr = 8'h00;
            for (int i = 0; i < abort_at; i++)
                exp_oam[8'(ptr0 + 8'(i))] = src_byte({page, 8'(i)});
            check({tag, "_abort_puts"}, put_q.size(), abort_at);
            check({tag, "_abort_ptr"}, {24'd0, oam_addr}, 32'h0);
            check({tag, "_abort_oam_diffs"}, oam_diff(), 0);
        end else begin
            cpu_ce = 1'b1;
            for (int k = 0; k < 4; k++) begin
                settle();
                advance();
            end
            for (int i = 0; i < 256; i++)
                exp_oam[8'(ptr0 + 8'(i))] = src_byte({page, 8'(i)});
            check({tag, "_halt_len"}, halt_cycles, exp_len);
            check({tag, "_done_pulses"}, done_pulses, 1);
            check({tag, "_put_count"}, put_q.size(), 256);
            check({tag, "_parity_viol"}, parity_viol, 0);
            check({tag, "_rd_count"}, rd_q.size(), 256);
            bad = 0;
            for (int i = 0; i < rd_q.size(); i++)
                if (rd_q[i] !== {page, 8'(i)}) bad++;
            check({tag, "_rd_addr_seq"}, bad, 0);
            bad = 0;
            for (int i = 0; i < put_q.size(); i++)
                if (put_q[i] !== 8'(ptr0 + 8'(i))) bad++;
            check({tag, "_put_addr_seq"}, bad, 0);
            check({tag, "_final_ptr"}, {24'd0, oam_addr}, {24'd0, ptr0});
            check({tag, "_oam_diffs"}, oam_diff(), 0);
        end
    endtask

    typedef struct {
        logic       ce;
        logic       sel;
        logic [7:0] data;
        logic       rend;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n_we;
        logic exp_we;

        vecs[0] = '{1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'hAB, 1'b0, 1'b1, 8'h10, 8'hAB};
        vecs[2] = '{1'b1, 1'b1, 8'hCD, 1'b0, 1'b1, 8'h11, 8'hCD};
        vecs[3] = '{1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 8'h12, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h21, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 8'h25, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h25, 8'h00};
        vecs[7] = '{1'b1, 1'b1, 8'hE1, 1'b0, 1'b1, 8'hFF, 8'hE1};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};

        for (int i = 0; i < 256; i++) begin
            sink[i] = 8'h00;
            exp_oam[i] = 8'h00;
        end
        model_ptr = 8'h00;
        ce_count = 0;
        halt_cycles = 0; done_pulses = 0; parity_viol = 0;

        // Reset state
        reset = 1'b1; cpu_ce = 1'b1; dma_start = 1'b0; dma_page = 8'h00;
        reg_wr = 1'b0; reg_sel = 1'b0; reg_data = 8'h00; rendering = 1'b0;
        advance();
        advance();
        check("rst_cpu_rdy", {31'd0, cpu_rdy}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_oam_we", {31'd0, oam_we}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_oam_addr", {24'd0, oam_addr}, 32'd0);
        reset = 1'b0;
        ce_count = 0;

        // Table-driven register writes
        for (int i = 0; i < 9; i++) begin
            cpu_ce = vecs[i].ce; reg_wr = 1'b1; reg_sel = vecs[i].sel;
            reg_data = vecs[i].data; rendering = vecs[i].rend;
            settle();
            check($sformatf("vec%0d_we", i), {31'd0, oam_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_addr", i), {24'd0, oam_addr}, {24'd0, vecs[i].exp_addr});
            if (vecs[i].exp_we)
                check($sformatf("vec%0d_data", i), {24'd0, oam_data}, {24'd0, vecs[i].exp_data});
            advance();
            model_reg(vecs[i].ce, 1'b1, vecs[i].sel, vecs[i].data, vecs[i].rend);
        end
        reg_wr = 1'b0;
        check("tbl_oam10", {24'd0, sink[8'h10]}, 32'hAB);
        check("tbl_oam11", {24'd0, sink[8'h11]}, 32'hCD);
        check("tbl_oamff", {24'd0, sink[8'hFF]}, 32'hE1);

        // Randomised idle register traffic against the model
        n_we = 0;
        for (int i = 0; i < 200; i++) begin
            cpu_ce    = ($urandom_range(0, 3) != 0);
            reg_wr    = 1'($urandom_range(0, 1));
            reg_sel   = 1'($urandom_range(0, 1));
            reg_data  = 8'($urandom_range(0, 255));
            rendering = 1'($urandom_range(0, 1));
            dma_start = 1'b0;
            exp_we = cpu_ce && reg_wr && (reg_sel == REG_OAMDATA) && !rendering;
            settle();
            check("rnd_we", {31'd0, oam_we}, {31'd0, exp_we});
            check("rnd_ptr", {24'd0, oam_addr}, {24'd0, model_ptr});
            if (exp_we) begin
                check("rnd_data", {24'd0, oam_data}, {24'd0, reg_data});
                n_we++;
            end
            advance();
            model_reg(cpu_ce, reg_wr, reg_sel, reg_data, rendering);
        end
        reg_wr = 1'b0;
        check("rnd_oam_diffs", oam_diff(), 0);

        // DMA page $02 from pointer 0, HALT on parity 1
        idle_op(1'b1, 1'b1, REG_OAMADDR, 8'h00, 1'b0);
        align_parity(1);
        run_dma("dma_odd", 8'h02, 1'b0, 8'h00, 100, 1'b0, 0);

        // Same transfer, HALT on parity 0, sparse cpu_ce and bus noise
        for (int i = 0; i < 256; i++) sink[i] = 8'h00;
        align_parity(0);
        run_dma("dma_even", 8'h02, 1'b0, 8'h00, 60, 1'b1, 0);

        // Pointer wrap: $2003<=$F0 in the same cycle as the $4014 write
        run_dma("dma_wrap", 8'h03, 1'b1, 8'hF0, 100, 1'b0, 0);
        check("wrap_put0", {24'd0, put_q[0]}, 32'hF0);
        check("wrap_put16", {24'd0, put_q[16]}, 32'h00);

        // Reset after the 100th PUT, then a clean restart
        idle_op(1'b1, 1'b1, REG_OAMADDR, 8'h00, 1'b0);
        run_dma("dma_abort", 8'h02, 1'b0, 8'h00, 100, 1'b0, 100);
        run_dma("dma_restart", 8'h04, 1'b0, 8'h00, 80, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_oam_dma.md
Name: ppu_oam_dma

Overview:
- Controller and arbiter for the PPU's 256-byte primary OAM write port.
- Sequences the $4014 page DMA: halts the CPU, reads 256 bytes from CPU page $XX00-$XXFF and writes them into OAM starting at the current OAM pointer.
- Owns the OAMADDR ($2003) pointer and serializes CPU $2004 writes onto the same port.
- Outputs drive the sprite unit's oam_addr / oam_data_in / oam_dma inputs.

Parameters:
XFER_LEN, 256, bytes per DMA; power of two, at most 256.
ADDR_W, 16, CPU bus address width.

Ports:
clk  in  1  clock (PPU domain)
reset  in  1  async, active-high
cpu_ce  in  1  CPU-cycle enable; all sequencing advances only when high
dma_start  in  1  CPU write to $4014 (qualified with cpu_ce)
dma_page  in  8  data written to $4014 (source page)
reg_wr  in  1  CPU write to $2003/$2004 (qualified with cpu_ce)
reg_sel  in  1  0=$2003 OAMADDR, 1=$2004 OAMDATA
reg_data  in  8  CPU write data
rendering  in  1  PPU is rendering (visible or prerender line, rendering enabled)
mem_addr  out  ADDR_W  DMA read address to CPU bus
mem_rd  out  1  DMA read strobe
mem_data_in  in  8  CPU bus read data, valid at end of a GET cycle
cpu_rdy  out  1  0 halts the CPU
oam_addr  out  8  OAM write address / current pointer
oam_data  out  8  OAM write data
oam_we  out  1  OAM write enable (to the sprite unit's oam_dma)
busy  out  1  DMA in progress
done  out  1  one-cpu_ce pulse after the final PUT

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, cpu_rdy=1, busy=0, done=0, oam_we=0, mem_rd=0, mem_addr=0, oam_ptr=0, parity=0, cnt=0, data latch=0.
- parity toggles on every clk where cpu_ce=1. GET is legal only on cycles with parity=0; PUT occurs only on cycles with parity=1.
- States: IDLE, HALT, ALIGN, GET, PUT. State changes happen only on cpu_ce edges. Outputs are Moore, decoded from state and registers.
- IDLE:
  - dma_start -> HALT; latch page=dma_page; cnt=0; cpu_rdy=0 from the next cycle.
  - dma_start while not IDLE is ignored.
- HALT: one dummy cycle. If current parity=1 -> GET, else -> ALIGN.
- ALIGN: one extra dummy cycle -> GET.
- Total halt length from the first HALT cycle through the last PUT, inclusive:
  - 513 cpu cycles if HALT lands on parity=1.
  - 514 cpu cycles if HALT lands on parity=0.
- GET:
  - mem_addr={page,cnt[7:0]}; mem_rd=1.
  - Latch mem_data_in on the closing cpu_ce edge.
  - -> PUT.
- PUT:
  - oam_we=1; oam_addr=oam_ptr; oam_data=latch.
  - On exit: oam_ptr+=1 (8-bit wrap); cnt+=1.
  - cnt==XFER_LEN-1 -> IDLE, with done=1 for one cpu_ce cycle and cpu_rdy=1. Otherwise -> GET.
- OAM pointer wrap: DMA starting at oam_ptr=$F0 writes $F0..$FF, then $00..$EF. oam_ptr ends equal to its start value.
- Register writes, IDLE only:
  - $2003: oam_ptr=reg_data.
  - $2004 with rendering=0: oam_we=1 for that cycle, addr=oam_ptr, data=reg_data; then oam_ptr+=1.
  - $2004 with rendering=1: no write; oam_ptr+=4 (bumps bits [7:2]).
- Register writes while busy are dropped, with no pointer change.
- Same-cycle reg_wr and dma_start in IDLE: the register effect is applied first; the DMA uses the updated oam_ptr.
- The DMA writes OAM regardless of rendering.
- oam_we is never asserted outside PUT or an accepted $2004 write. At most one OAM write per cpu_ce cycle.
- cpu_ce=0: all registers hold and oam_we/mem_rd are held. The downstream must qualify them with cpu_ce, or the implementation gates them; gating is decided: oam_we and mem_rd are ANDed with cpu_ce.
- Reset mid-transfer: immediate return to IDLE. cpu_rdy=1; no further OAM writes; partial OAM contents are retained.

Decomposition:
- ppu_pkg holds:
  - typedef enum dma_state_t {IDLE,HALT,ALIGN,GET,PUT};
  - localparams REG_OAMADDR=1'b0, REG_OAMDATA=1'b1, OAM_SIZE=256.
- Single module, no sub-module. The parity flop and counters are too small to split out.

Test Plan:
- $2003<=$10, $2004<=$AB,$CD with rendering=0 -> OAM[$10]=$AB, OAM[$11]=$CD; oam_ptr=$12.
- dma_start page=$02 at parity=1, memory[$0200+i]=i^$5A, oam_ptr=0 -> cpu_rdy low for exactly 513 cpu cycles; OAM[i]=i^$5A for all i; done pulses once; oam_ptr=0.
- Same transfer started at parity=0 -> 514-cycle halt, with the ALIGN state visited once; OAM contents are identical.
- $2003<=$F0 then DMA page=$03 -> first PUT at addr $F0; 17th PUT at addr $00; final oam_ptr=$F0.
- $2004 write with rendering=1, oam_ptr=$21 -> no oam_we; oam_ptr=$25.
- reset asserted after the 100th PUT -> cpu_rdy=1 within the same cycle; OAM[0..99] updated, OAM[100..255] unchanged; a new dma_start restarts cleanly.
